vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 150 +++++++++++++++
 tb/tb_vram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port RAM between VGA scanout reads and
// CPU read/write accesses. VGA has priority; a CPU that has been refused
// MAX_WAIT eligible cycles in a row overrides it. Reads return two edges
// after the grant, tracked by a small owner-tag pipeline.
module vram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 7
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_miss,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    // Counter only needs to reach MAX_WAIT; keep at least one bit for MAX_WAIT=0.
    localparam int            CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_BUSY = 2'd1;
    localparam logic [1:0] C_GAP  = 2'd2;

    // One in-flight access: who owns it and whether it returns read data.
    typedef struct packed {
        logic vld;
        logic cpu;
        logic rd;
    } tag_t;

    logic              cpu_elig, override, gnt_vga, gnt_cpu;
    logic [1:0]        cst_q, cst_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    tag_t [1:0]        tag_q, tag_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              vga_gnt_q, vga_gnt_d, vga_miss_q, vga_miss_d;
    logic              vga_rvalid_q, vga_rvalid_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    // Arbitration, RAM command, return path and CPU state next-values.
    always_comb begin
        cpu_elig = cpu_req && (cst_q == C_IDLE);
        override = cpu_elig && (wait_cnt_q >= WAIT_MAX);
        gnt_vga  = vga_req && !override;
        gnt_cpu  = cpu_elig && !gnt_vga;

        mem_en_d    = gnt_vga || gnt_cpu;
        mem_we_d    = gnt_cpu && cpu_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (gnt_cpu) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
        end else if (gnt_vga) begin
            mem_addr_d  = vga_addr;
        end

        vga_gnt_d  = gnt_vga;
        vga_miss_d = vga_req && override;

        tag_d[0].vld = gnt_vga || gnt_cpu;
        tag_d[0].cpu = gnt_cpu;
        tag_d[0].rd  = !(gnt_cpu && cpu_we);
        tag_d[1]     = tag_q[0];

        // RAM data for a tag in the last stage is on mem_rdata right now.
        vga_rvalid_d = tag_q[1].vld && !tag_q[1].cpu;
        vga_rdata_d  = vga_rvalid_d ? mem_rdata : vga_rdata_q;
        cpu_ack_d    = tag_q[1].vld && tag_q[1].cpu;
        cpu_rdata_d  = (cpu_ack_d && tag_q[1].rd) ? mem_rdata : cpu_rdata_q;

        wait_cnt_d = wait_cnt_q;
        if (!cpu_req || gnt_cpu)
            wait_cnt_d = '0;
        else if (cpu_elig && (wait_cnt_q < WAIT_MAX))
            wait_cnt_d = wait_cnt_q + CW'(1);

        // GAP keeps a held cpu_req from being regranted right after its ack.
        cst_d = cst_q;
        case (cst_q)
            C_IDLE:  if (gnt_cpu) cst_d = C_BUSY;
            C_BUSY:  if (cpu_ack_d) cst_d = C_GAP;
            C_GAP:   cst_d = C_IDLE;
            default: cst_d = C_IDLE;
        endcase
    end

    // State registers; reset drops any in-flight access.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            cst_q        <= C_IDLE;
            wait_cnt_q   <= '0;
            tag_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            vga_gnt_q    <= 1'b0;
            vga_miss_q   <= 1'b0;
            vga_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            cst_q        <= cst_d;
            wait_cnt_q   <= wait_cnt_d;
            tag_q        <= tag_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            vga_gnt_q    <= vga_gnt_d;
            vga_miss_q   <= vga_miss_d;
            vga_rvalid_q <= vga_rvalid_d;
            vga_rdata_q  <= vga_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign vga_gnt    = vga_gnt_q;
    assign vga_miss   = vga_miss_q;
    assign vga_rvalid = vga_rvalid_q;
    assign vga_rdata  = vga_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a RAM model drives mem_rdata, and a transaction-level
// reference (edge numbers, an event queue, a shadow memory) predicts outputs.
module tb_vram_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int MW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_gnt, vga_miss, vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk_50mhz(clk), .rst_n(rst_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_miss(vga_miss), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 16'h0301) ^ 16'h5A3C;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            at;
        bit            cpu;
        bit            rd;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           evq[$];
    logic [DW-1:0] shm [0:4095];
    int            n = 0;       // edge number
    int            cpu_ok = 0;  // first edge at which the CPU may be granted again
    int            w = 0;       // refused-eligible streak
    bit            m_busy = 0, m_cgnt = 0;
    logic          e_mem_en, e_mem_we, e_vgnt, e_vmiss, e_vrv, e_ack;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata, e_vrd, e_crd;

    task automatic model_reset();
        evq.delete();
        cpu_ok = 0; w = 0; m_busy = 0; m_cgnt = 0;
        e_mem_en = 0; e_mem_we = 0; e_vgnt = 0; e_vmiss = 0; e_vrv = 0; e_ack = 0;
        e_mem_addr = '0; e_mem_wdata = '0; e_vrd = '0; e_crd = '0;
    endtask

    task automatic model_edge();
        bit elig, ovr, vg, cg;
        ev_t ev;
        n++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_mem_en = 0; e_mem_we = 0; e_vgnt = 0; e_vmiss = 0; e_vrv = 0; e_ack = 0; m_cgnt = 0;
        while (evq.size() > 0 && evq[0].at == n) begin
            ev = evq.pop_front();
            if (ev.cpu) begin
                e_ack = 1; m_busy = 0;
                if (ev.rd) e_crd = ev.data;
            end else begin
                e_vrv = 1; e_vrd = ev.data;
            end
        end
        elig = cpu_req && (n >= cpu_ok);
        ovr  = elig && (w >= MW);
        vg   = vga_req && !ovr;
        cg   = elig && !vg;
        e_vgnt  = vg;
        e_vmiss = vga_req && ovr;
        if (cg) begin
            e_mem_en = 1; e_mem_we = cpu_we; e_mem_addr = cpu_addr; e_mem_wdata = cpu_wdata;
            ev.at = n + 2; ev.cpu = 1; ev.rd = !cpu_we; ev.data = shm[cpu_addr];
            if (cpu_we) shm[cpu_addr] = cpu_wdata;
            evq.push_back(ev);
            cpu_ok = n + 4; m_busy = 1; m_cgnt = 1;
        end else if (vg) begin
            e_mem_en = 1; e_mem_addr = vga_addr;
            ev.at = n + 2; ev.cpu = 0; ev.rd = 1; ev.data = shm[vga_addr];
            evq.push_back(ev);
        end
        if (!cpu_req || cg) w = 0;
        else if (elig && w < MW) w = w + 1;
    endtask

    task automatic compare_all();
        chk("mem_en", 32'(mem_en), 32'(e_mem_en));
        chk("mem_we", 32'(mem_we), 32'(e_mem_we));
        if (e_mem_en) chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
        if (e_mem_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
        chk("vga_gnt", 32'(vga_gnt), 32'(e_vgnt));
        chk("vga_miss", 32'(vga_miss), 32'(e_vmiss));
        chk("vga_rvalid", 32'(vga_rvalid), 32'(e_vrv));
        chk("vga_rdata", 32'(vga_rdata), 32'(e_vrd));
        chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
        chk("wait_cnt", 32'(dut.wait_cnt_q), 32'(w));
    endtask

    // One clock: model sees the inputs present at the edge, outputs checked 1ns later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] any_out();
        return 32'(|{mem_en, mem_we, mem_addr, mem_wdata, vga_gnt, vga_miss,
                     vga_rvalid, vga_rdata, cpu_ack, cpu_rdata});
    endfunction

    // Run one CPU access; inputs are scrambled after grant to prove they were latched.
    task automatic cpu_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit drop, output int g_edge, output int a_edge);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        g_edge = -1; a_edge = -1;
        for (int i = 0; i < 30 && a_edge < 0; i++) begin
            cyc();
            if (m_cgnt) begin
                g_edge = n; cpu_we = !we; cpu_addr = ~a; cpu_wdata = ~d;
            end
            if (cpu_ack) a_edge = n;
        end
        if (a_edge < 0) chk("cpu_ack_timeout", 0, 1);
        if (drop) cpu_req = 0;
    endtask

    initial begin
        int g1, a1, g2, a2, cnt_g, cnt_m, cnt_rv, cnt_any, got_cpu;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = init_val(i);
            shm[i] = init_val(i);
        end
        model_reset();

        // reset state
        #2 rst_n = 0;
        #1 chk("reset_outs", any_out(), 0);
        cyc(); cyc();
        rst_n = 1;

        // idle: nothing requested for 20 cycles
        cnt_any = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            cnt_any += int'(mem_en | vga_gnt | vga_miss | vga_rvalid | cpu_ack);
        end
        chk("idle_activity", 32'(cnt_any), 0);

        // VGA streaming addr 0..9
        cnt_g = 0; cnt_m = 0; cnt_rv = 0;
        for (int i = 0; i < 13; i++) begin
            vga_req  = (i < 10);
            vga_addr = AW'(i);
            cyc();
            cnt_g += int'(vga_gnt);
            cnt_m += int'(vga_miss);
            if (vga_rvalid) begin
                chk("stream_data", 32'(vga_rdata), 32'(init_val(cnt_rv)));
                cnt_rv++;
            end
        end
        vga_req = 0;
        chk("stream_gnts", 32'(cnt_g), 10);
        chk("stream_miss", 32'(cnt_m), 0);
        chk("stream_rvalids", 32'(cnt_rv), 10);

        // CPU write then read, req held through the first ack
        cpu_txn(1'b1, 12'h123, 16'hA5C3, 1'b0, g1, a1);
        cpu_txn(1'b0, 12'h123, 16'h0000, 1'b1, g2, a2);
        chk("wr_ack_latency", 32'(a1 - g1), 2);
        chk("rd_ack_latency", 32'(a2 - g2), 2);
        chk("rd_data", 32'(cpu_rdata), 32'hA5C3);
        chk("regrant_after_ack", 32'(g2 - a1), 2);

        // simultaneous requests: starvation override
        for (int i = 0; i < 3; i++) cyc();
        vga_req = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
        cnt_g = 0; cnt_m = 0; got_cpu = 0;
        for (int i = 0; i < 20 && !got_cpu; i++) begin
            vga_addr = AW'(16 + i);
            cyc();
            cnt_g += int'(vga_gnt);
            cnt_m += int'(vga_miss);
            if (mem_en && !vga_gnt) got_cpu = 1;
        end
        chk("starve_cpu_granted", 32'(got_cpu), 1);
        chk("starve_vga_wins", 32'(cnt_g), 7);
        chk("starve_miss", 32'(cnt_m), 1);
        chk("starve_wait_clr", 32'(dut.wait_cnt_q), 0);
        vga_req = 0;
        cyc(); cyc();
        chk("starve_ack", 32'(cpu_ack), 1);
        cpu_req = 0;
        for (int i = 0; i < 3; i++) cyc();

        // reset one cycle after a CPU grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h040;
        got_cpu = 0;
        for (int i = 0; i < 10 && !got_cpu; i++) begin
            cyc();
            got_cpu = int'(m_cgnt);
        end
        chk("pre_rst_grant", 32'(got_cpu), 1);
        cyc();
        rst_n = 0;
        #1 chk("midop_reset_outs", any_out(), 0);
        model_reset();
        cyc(); cyc();
        rst_n = 1;
        cyc();
        chk("post_rst_grant", 32'(mem_en && !mem_we && mem_addr == 12'h040), 1);
        cnt_any = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            cnt_any += int'(cpu_ack);
        end
        chk("post_rst_acks", 32'(cnt_any), 1);
        cpu_req = 0;
        cyc(); cyc();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            vga_req  = ($urandom_range(0, 3) != 0);
            vga_addr = AW'($urandom_range(0, 63));
            if (cpu_ack) begin
                cpu_req   = $urandom_range(0, 1) != 0;
                cpu_we    = $urandom_range(0, 1) != 0;
                cpu_addr  = AW'($urandom_range(0, 63));
                cpu_wdata = DW'($urandom);
            end else if (!cpu_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    cpu_req   = 1;
                    cpu_we    = $urandom_range(0, 1) != 0;
                    cpu_addr  = AW'($urandom_range(0, 63));
                    cpu_wdata = DW'($urandom);
                end
            end else if (m_busy) begin
                cpu_we    = $urandom_range(0, 1) != 0;
                cpu_addr  = AW'($urandom);
                cpu_wdata = DW'($urandom);
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
